pu_lut_reader: RTL and testbench
================================

// Module: pu_lut_reader
// PURPOSE
//  Read-side initiator for the pu_lut processing unit: converts valid/ready lookup requests
//  into pu_lut control cycles (addr, sel, signal_oe), captures the LUT data output and returns
//  it on a valid/ready response channel. Also provides a sweep mode that reads every address
//  of a selected table in order (contents dump / self-check). Sits between the PU control
//  path and pu_lut; signal_wr of pu_lut is tied low at the top level, not driven here.
// PARAMETERS
//  ADDR_WIDTH    4  LUT address width; sweep covers 2**ADDR_WIDTH entries
//  DATA_WIDTH    1  LUT data width
//  SEL_WIDTH     2  table-select width
//  READ_LATENCY  1  cycles with signal_oe high before LUT data is valid; must be >=1 ($error at elaboration otherwise)
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           asynchronous, active-high reset
//  req_valid     in   1           single lookup request
//  req_ready     out  1           request accepted when valid&ready
//  req_addr      in   ADDR_WIDTH  lookup address
//  req_sel       in   SEL_WIDTH   lookup table select
//  sweep_start   in   1           pulse: start full-table sweep
//  sweep_sel     in   SEL_WIDTH   table swept
//  sweep_done    out  1           one-cycle pulse after last sweep response accepted
//  busy          out  1           high whenever not IDLE
//  rsp_valid     out  1           response valid
//  rsp_ready     in   1           response consumed when valid&ready
//  rsp_data      out  DATA_WIDTH  captured LUT data
//  rsp_addr      out  ADDR_WIDTH  address the data belongs to
//  lut_addr      out  ADDR_WIDTH  to pu_lut.addr
//  lut_sel       out  SEL_WIDTH   to pu_lut.sel
//  lut_oe        out  1           to pu_lut.signal_oe
//  lut_data      in   DATA_WIDTH  from pu_lut.data
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; lut_oe, lut_addr, lut_sel, rsp_valid, rsp_data,
//    rsp_addr, sweep_done = 0; in-flight lookup or sweep discarded, no response emitted.
//  - States: IDLE, ISSUE, RESP. req_ready = (state==IDLE) && !sweep_start (combinational).
//  - IDLE: sweep_start=1 -> latch sweep_sel, addr counter=0, mode=SWEEP, -> ISSUE; sweep wins
//    over a simultaneous req_valid (request not accepted). Else req_valid -> latch req_addr/
//    req_sel, mode=SINGLE, -> ISSUE.
//  - ISSUE: lut_addr/lut_sel = latched values, lut_oe=1 for exactly READ_LATENCY cycles
//    (latency counter); lut_data sampled on the edge ending the last such cycle into rsp_data,
//    rsp_addr=lut_addr; -> RESP. lut_addr/lut_sel stable throughout ISSUE.
//  - RESP: lut_oe=0; rsp_valid=1, rsp_data/rsp_addr held stable until rsp_ready.
//    On handshake: SINGLE -> IDLE; SWEEP and addr != 2**ADDR_WIDTH-1 -> addr+1, -> ISSUE;
//    SWEEP and last addr -> sweep_done=1 for one cycle, -> IDLE. No wrap to address 0.
//  - Latency: accept edge to rsp_valid = 1+READ_LATENCY cycles; back-to-back sweep entries
//    with rsp_ready=1 cost READ_LATENCY+1 cycles each.
//  - sweep_start / req_valid while busy: ignored (no queuing).
//  - rsp_ready held low: FSM stalls in RESP indefinitely, LUT not re-accessed.
//  - Address counter is ADDR_WIDTH bits with explicit last-address compare (no carry bit).
// STRUCTURE
//  - Shared package pu_lut_pkg: state encoding (IDLE/ISSUE/RESP), mode encoding (SINGLE/SWEEP),
//    default ADDR/DATA/SEL widths shared with pu_lut and its benches.
//  - One natural sub-module: pu_lut_sweep_cnt (address counter with clear, enable,
//    last-flag); latency counter stays inline.
// TESTING (bench loads pu_lut with dump where data = ^addr, ADDR=4, DATA=1, SEL=2)
//  1 Reset: assert rst mid-ISSUE -> all outputs 0 immediately, req_ready=1 after release, no rsp.
//  2 Single: req_addr=4'h7, req_sel=1, rsp_ready=1 -> lut_oe high READ_LATENCY cycles, rsp_valid
//    at accept+1+READ_LATENCY, rsp_data=1, rsp_addr=7; next req_ready=1 one cycle later.
//  3 Backpressure: req_addr=4'h3, rsp_ready low 5 cycles -> rsp_valid/rsp_data=0 held stable,
//    lut_oe=0 while stalled; completes on first rsp_ready.
//  4 Sweep: sweep_start, sweep_sel=2 -> 16 responses, rsp_addr 0..15 in order, rsp_data=^addr,
//    sweep_done pulses once after addr 15 accepted, busy drops same cycle as return to IDLE.
//  5 Collision: sweep_start and req_valid same IDLE cycle -> req_ready=0, sweep runs, request
//    re-presented after sweep_done is served normally.
//  6 Latency: rerun 2 and 4 with READ_LATENCY=3 -> 4-cycle accept-to-rsp, 4 cycles/entry sweep.

Source files
------------

// File: rtl/pu_lut_pkg.sv
// Shared encodings and default widths for pu_lut, its read-side initiator and benches.
// Pure declarations; no logic, no latency.
package pu_lut_pkg;

  localparam int LUT_ADDR_WIDTH = 4;
  localparam int LUT_DATA_WIDTH = 1;
  localparam int LUT_SEL_WIDTH  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_SWEEP  = 1'b1
  } mode_t;

endpackage

// File: rtl/pu_lut_sweep_cnt.sv
// Sweep address counter: synchronous clear, increment on enable, last-address flag.
// Zero latency on the flag; no backpressure of its own (the caller gates enable).
module pu_lut_sweep_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  // The caller never enables past the last address, so no carry bit is needed.
  assign last = (cnt == {WIDTH{1'b1}});

endmodule

// File: rtl/pu_lut_reader.sv
// Turns valid/ready lookups (or a full-table sweep) into pu_lut read cycles; rsp_valid 1+READ_LATENCY
// cycles after accept, READ_LATENCY+1 cycles per sweep entry; rsp_ready low stalls in RESP with the LUT idle.
module pu_lut_reader
  import pu_lut_pkg::*;
#(
  parameter int ADDR_WIDTH   = LUT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = LUT_DATA_WIDTH,
  parameter int SEL_WIDTH    = LUT_SEL_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [SEL_WIDTH-1:0]  req_sel,
  input  logic                  sweep_start,
  input  logic [SEL_WIDTH-1:0]  sweep_sel,
  output logic                  sweep_done,
  output logic                  busy,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  output logic [SEL_WIDTH-1:0]  lut_sel,
  output logic                  lut_oe,
  input  logic [DATA_WIDTH-1:0] lut_data
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("pu_lut_reader: READ_LATENCY must be at least 1");
  end

  state_t                state;
  state_t                state_nxt;
  mode_t                 mode;
  logic [ADDR_WIDTH-1:0] single_addr;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [LAT_W-1:0]      lat_cnt;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic                  sweep_last;
  logic                  cnt_clr;
  logic                  cnt_en;
  logic                  issue_done;
  logic                  rsp_fire;

  pu_lut_sweep_cnt #(
    .WIDTH(ADDR_WIDTH)
  ) u_sweep_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (sweep_addr),
    .last(sweep_last)
  );

  assign issue_done = (state == ST_ISSUE) && (lat_cnt == LAT_LAST);
  assign rsp_fire   = (state == ST_RESP) && rsp_ready;

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        // A sweep request outranks a simultaneous single lookup.
        if (sweep_start) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_ISSUE;
        end else if (req_valid) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_done) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if ((mode == MODE_SWEEP) && !sweep_last) begin
            cnt_en    = 1'b1;
            state_nxt = ST_ISSUE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      mode        <= MODE_SINGLE;
      single_addr <= '0;
      sel_q       <= '0;
      lat_cnt     <= '0;
      rsp_data    <= '0;
      rsp_addr    <= '0;
      sweep_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sweep_done <= rsp_fire && (mode == MODE_SWEEP) && sweep_last;
      if (state == ST_IDLE) begin
        if (sweep_start) begin
          mode  <= MODE_SWEEP;
          sel_q <= sweep_sel;
        end else if (req_valid) begin
          mode        <= MODE_SINGLE;
          single_addr <= req_addr;
          sel_q       <= req_sel;
        end
      end
      if ((state == ST_ISSUE) && !issue_done) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end else begin
        lat_cnt <= '0;
      end
      if (issue_done) begin
        rsp_data <= lut_data;
        rsp_addr <= lut_addr;
      end
    end
  end

  assign req_ready = (state == ST_IDLE) && !sweep_start;
  assign busy      = (state != ST_IDLE);
  assign lut_oe    = (state == ST_ISSUE);
  assign rsp_valid = (state == ST_RESP);
  assign lut_addr  = (mode == MODE_SWEEP) ? sweep_addr : single_addr;
  assign lut_sel   = sel_q;

endmodule

// File: tb/tb_pu_lut_reader.sv
// Drives two readers (READ_LATENCY 1 and 3) against a behavioural LUT whose data is ^addr only
// on the final oe cycle; a scoreboard monitor checks every response, its timing and sweep_done.
module tb_pu_lut_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid[2], req_ready[2], sweep_start[2], sweep_done[2], busy[2];
  logic       rsp_valid[2], rsp_ready[2], lut_oe[2], rsp_data[2], lut_data[2];
  logic [3:0] req_addr[2], rsp_addr[2], lut_addr[2];
  logic [1:0] req_sel[2], sweep_sel[2], lut_sel[2];

  typedef struct {
    int         d;
    logic [3:0] addr;
    logic [1:0] sel;
    logic       data;
    bit         fin;
    bit         sw_last;
  } exp_t;

  exp_t sbq[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   oe_run[2];
  int   last_evt[2];
  bit   wait_new[2], pend_fin[2], pend_sw[2];
  int   rdy_pct = 100;
  bit   hold_low = 0;

  always #5 clk = ~clk;

  pu_lut_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(1), .SEL_WIDTH(2), .READ_LATENCY(1)) u_rl1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_sel(req_sel[0]), .sweep_start(sweep_start[0]),
    .sweep_sel(sweep_sel[0]), .sweep_done(sweep_done[0]), .busy(busy[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_addr(rsp_addr[0]), .lut_addr(lut_addr[0]), .lut_sel(lut_sel[0]),
    .lut_oe(lut_oe[0]), .lut_data(lut_data[0]));

  pu_lut_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(1), .SEL_WIDTH(2), .READ_LATENCY(3)) u_rl3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_sel(req_sel[1]), .sweep_start(sweep_start[1]),
    .sweep_sel(sweep_sel[1]), .sweep_done(sweep_done[1]), .busy(busy[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_addr(rsp_addr[1]), .lut_addr(lut_addr[1]), .lut_sel(lut_sel[1]),
    .lut_oe(lut_oe[1]), .lut_data(lut_data[1]));

  function automatic int rl(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // LUT model: correct data only once oe has been high for READ_LATENCY cycles.
  assign lut_data[0] = (lut_oe[0] && oe_run[0] == rl(0) - 1) ? ^lut_addr[0] : ~(^lut_addr[0]);
  assign lut_data[1] = (lut_oe[1] && oe_run[1] == rl(1) - 1) ? ^lut_addr[1] : ~(^lut_addr[1]);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) oe_run[d] <= lut_oe[d] ? oe_run[d] + 1 : 0;
  end

  always begin
    @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++)
      rsp_ready[d] = hold_low ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        wait_new[d] = 1;
        pend_fin[d] = 0;
        pend_sw[d]  = 0;
      end else begin
        if (pend_fin[d]) begin
          chk("idle_busy", {31'd0, busy[d]}, 0);
          chk("idle_req_ready", {31'd0, req_ready[d]}, {31'd0, !sweep_start[d]});
        end
        if (sweep_done[d] || pend_sw[d])
          chk("sweep_done", {31'd0, sweep_done[d]}, {31'd0, pend_sw[d]});
        pend_fin[d] = 0;
        pend_sw[d]  = 0;
        if ((req_valid[d] && req_ready[d]) || (sweep_start[d] && !busy[d])) last_evt[d] = cyc;
        if (lut_oe[d]) begin
          if (sbq.size() == 0 || sbq[0].d != d) chk("unexpected_oe", 1, 0);
          else begin
            chk("lut_addr", {28'd0, lut_addr[d]}, {28'd0, sbq[0].addr});
            chk("lut_sel", {30'd0, lut_sel[d]}, {30'd0, sbq[0].sel});
          end
        end
        if (rsp_valid[d]) begin
          if (sbq.size() == 0 || sbq[0].d != d) chk("unexpected_rsp", 1, 0);
          else begin
            chk("rsp_addr", {28'd0, rsp_addr[d]}, {28'd0, sbq[0].addr});
            chk("rsp_data", {31'd0, rsp_data[d]}, {31'd0, sbq[0].data});
            chk("oe_in_resp", {31'd0, lut_oe[d]}, 0);
            if (wait_new[d]) begin
              chk("rsp_latency", cyc - last_evt[d], 1 + rl(d));
              wait_new[d] = 0;
            end
            if (rsp_ready[d]) begin
              pend_fin[d] = sbq[0].fin;
              pend_sw[d]  = sbq[0].sw_last;
              void'(sbq.pop_front());
              last_evt[d] = cyc;
              wait_new[d] = 1;
            end
          end
        end
      end
    end
  end

  function automatic void push(int d, logic [3:0] a, logic [1:0] s, bit fin, bit swl);
    exp_t e;
    e.d = d; e.addr = a; e.sel = s; e.data = ^a; e.fin = fin; e.sw_last = swl;
    sbq.push_back(e);
  endfunction

  task automatic wait_req_ack(int d);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[d] && t < 3000);
    if (t >= 3000) chk("req_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(int d, logic [3:0] a, logic [1:0] s);
    push(d, a, s, 1, 0);
    @(posedge clk);
    #1;
    req_valid[d] = 1; req_addr[d] = a; req_sel[d] = s;
    wait_req_ack(d);
    req_valid[d] = 0; req_addr[d] = 4'($urandom); req_sel[d] = 2'($urandom);
  endtask

  task automatic push_sweep(int d, logic [1:0] s);
    for (int a = 0; a < 16; a++) push(d, 4'(a), s, a == 15, a == 15);
  endtask

  task automatic do_sweep(int d, logic [1:0] s);
    push_sweep(d, s);
    @(posedge clk);
    #1;
    sweep_start[d] = 1; sweep_sel[d] = s;
    @(posedge clk);
    #1;
    sweep_start[d] = 0; sweep_sel[d] = 2'($urandom);
  endtask

  task automatic wait_idle(int d);
    int t = 0;
    while ((sbq.size() != 0 || busy[d]) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("idle_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(int d);
    chk("rst_lut_oe", {31'd0, lut_oe[d]}, 0);
    chk("rst_lut_addr", {28'd0, lut_addr[d]}, 0);
    chk("rst_lut_sel", {30'd0, lut_sel[d]}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid[d]}, 0);
    chk("rst_rsp_data", {31'd0, rsp_data[d]}, 0);
    chk("rst_rsp_addr", {28'd0, rsp_addr[d]}, 0);
    chk("rst_sweep_done", {31'd0, sweep_done[d]}, 0);
    chk("rst_busy", {31'd0, busy[d]}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_addr[d] = 0; req_sel[d] = 0;
      sweep_start[d] = 0; sweep_sel[d] = 0;
    end
    #12;
    for (int d = 0; d < 2; d++) chk_zero(d);
    @(posedge clk);
    #2 rst = 0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk("post_rst_req_ready", {31'd0, req_ready[d]}, 1);

    for (int d = 0; d < 2; d++) begin
      // single lookup
      do_req(d, 4'h7, 2'd1);
      wait_idle(d);

      // held backpressure
      hold_low = 1;
      do_req(d, 4'h3, 2'd2);
      begin
        int t = 0;
        while (!rsp_valid[d] && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (t >= 100) chk("bp_rsp_timeout", 1, 0);
      end
      repeat (5) @(posedge clk);
      hold_low = 0;
      wait_idle(d);

      // full sweep, table 2
      do_sweep(d, 2'd2);
      wait_idle(d);

      // sweep and request collide: sweep wins, request served afterwards
      push_sweep(d, 2'd3);
      push(d, 4'h9, 2'd1, 1, 0);
      @(posedge clk);
      #1;
      sweep_start[d] = 1; sweep_sel[d] = 2'd3;
      req_valid[d] = 1; req_addr[d] = 4'h9; req_sel[d] = 2'd1;
      #1 chk("collision_req_ready", {31'd0, req_ready[d]}, 0);
      @(posedge clk);
      #1 sweep_start[d] = 0;
      wait_req_ack(d);
      req_valid[d] = 0;
      wait_idle(d);

      // reset while the LUT is being read
      push(d, 4'h5, 2'd0, 1, 0);
      @(posedge clk);
      #1;
      req_valid[d] = 1; req_addr[d] = 4'h5; req_sel[d] = 2'd1;
      wait_req_ack(d);
      req_valid[d] = 0;
      #2 rst = 1;
      #1 chk_zero(d);
      sbq.delete();
      @(posedge clk);
      #3 rst = 0;
      repeat (5) @(posedge clk);
      #1 chk("rst_release_req_ready", {31'd0, req_ready[d]}, 1);

      // random lookups and a sweep under random backpressure; a stray sweep_start mid-sweep is ignored
      rdy_pct = 60;
      for (int i = 0; i < 12; i++) do_req(d, 4'($urandom), 2'($urandom));
      wait_idle(d);
      do_sweep(d, 2'($urandom));
      repeat (10) @(posedge clk);
      #1;
      sweep_start[d] = 1; sweep_sel[d] = 2'd1;
      @(posedge clk);
      #1 sweep_start[d] = 0;
      wait_idle(d);
      rdy_pct = 100;
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
